lsu_mem_initiator: RTL

Load/store initiator for the MEM stage: accepts one load or store request from the pipeline over a valid/ready handshake, checks alignment and range, and drives the 4 KB data memory's port (address, write data, write enable, byte/half/word mode). It captures and sign- or zero-extends load data and returns a response over a second valid/ready handshake. It is the requesting end of the data-memory interface; the data memory itself is unchanged.

---
 rtl/lsu_mem_initiator.sv | 135 +++++++++++++
 1 files changed

// File: rtl/lsu_mem_initiator.sv
// MEM-stage load/store initiator: one outstanding request, alignment/range check,
// drives the 4 KB data memory port and returns extended load data.
module lsu_mem_initiator #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic [11:0] mem_addr_o,
    output logic [31:0] mem_din_o,
    output logic        mem_we_o,
    output logic [1:0]  mem_mode_o,
    input  logic [31:0] mem_dout_i
);

    localparam logic [1:0] MEM_OP_BYTE = 2'b01;
    localparam logic [1:0] MEM_OP_HALF = 2'b10;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        uns;
    } req_t;

    state_t      state_q;
    req_t        req_q;
    logic        req_ready_q;
    logic        resp_valid_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        in_range;
    logic        misalign;
    logic        req_err;
    logic [31:0] load_ext;

    assign in_range = (req_addr_i[31:12] == BASE_ADDR[31:12]);

    always_comb begin
        misalign = 1'b0;
        case (req_size_i)
            MEM_OP_BYTE: misalign = 1'b0;
            MEM_OP_HALF: misalign = req_addr_i[0];
            default:     misalign = (req_addr_i[1:0] != 2'b00);
        endcase
    end

    assign req_err = misalign | ~in_range;

    // Memory already zero-extends its lane, so only signed loads need work here.
    always_comb begin
        load_ext = mem_dout_i;
        if (!req_q.uns) begin
            case (req_q.size)
                MEM_OP_BYTE: load_ext = {{24{mem_dout_i[7]}}, mem_dout_i[7:0]};
                MEM_OP_HALF: load_ext = {{16{mem_dout_i[15]}}, mem_dout_i[15:0]};
                default:     load_ext = mem_dout_i;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            req_q        <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        req_q.we    <= req_we_i;
                        req_q.addr  <= req_addr_i;
                        req_q.wdata <= req_wdata_i;
                        req_q.size  <= req_size_i;
                        req_q.uns   <= req_unsigned_i;
                        rdata_q     <= '0;
                        err_q       <= req_err;
                        req_ready_q <= 1'b0;
                        if (req_err) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                        end else begin
                            state_q <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    rdata_q      <= req_q.we ? 32'h0 : load_ext;
                    resp_valid_q <= 1'b1;
                    state_q      <= RESP;
                end
                RESP: begin
                    if (resp_ready_i) begin
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    req_ready_q  <= 1'b1;
                    resp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Decoded from state so an async reset kills the write strobe at once.
    assign mem_we_o     = (state_q == ACCESS) & req_q.we;
    assign mem_addr_o   = req_q.addr[11:0];
    assign mem_din_o    = req_q.wdata;
    assign mem_mode_o   = req_q.size;
    assign req_ready_o  = req_ready_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = rdata_q;
    assign resp_err_o   = err_q;

endmodule
